conv_mac_pack: RTL and testbench

- Parametrised successor to the fixed 4-lane multiply / accumulate / pack datapath of the conv accelerator.
- Takes LANES paired ifm/weight operands per beat and reduces each beat to one partial sum.
- Accumulates cfg_taps beats per output neuron, then rescales, rounds, saturates and optionally applies ReLU.
- Packs PACK neuron results into one output-buffer word behind a valid/ready handshake; sits between the ifm/weight buffers and the output BRAM write port.

---
 rtl/conv_mac_pack.sv | 227 ++++++++++++++++++++++
 tb/tb_conv_mac_pack.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_pack.sv
// Multiply/accumulate/pack datapath: LANES operand pairs per beat, cfg_taps beats per neuron,
// rescale/round/saturate/ReLU, then PACK results per output word behind a valid/ready handshake.
`timescale 1ns/1ps
module conv_mac_pack #(
    parameter int LANES = 4,
    parameter int DW    = 16,
    parameter int ACCW  = 40,
    parameter int FRAC  = 8,
    parameter int PACK  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [15:0]           cfg_taps,
    input  logic [15:0]           cfg_neurons,
    input  logic                  cfg_relu,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   ifm,
    input  logic [LANES*DW-1:0]   wgt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PACK*DW-1:0]    out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DRAIN = 2'd3} state_t;

    localparam int SW  = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int RSH = (FRAC > 0) ? (FRAC - 1) : 0;
    localparam logic signed [ACCW-1:0] RND  = (FRAC > 0) ? ({{(ACCW-1){1'b0}}, 1'b1} << RSH) : {ACCW{1'b0}};
    localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] MINV = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    state_t                  state_r;
    logic [15:0]             taps_r, neurons_r, tap_cnt_r, neu_cnt_r;
    logic                    relu_r;
    logic                    stall_s, accept_s, first_s, tap_last_s, layer_last_s;

    logic signed [2*DW-1:0]  prod_r [LANES];
    logic                    v1_r, first1_r, last1_r, llast1_r;
    logic signed [ACCW-1:0]  acc_r, fin_r, sum_s, acc_nxt_s, rnd_s, shr_s;
    logic                    v2_r, llast2_r;
    logic [DW-1:0]           sat_s, res_s;
    logic [PACK*DW-1:0]      pack_r, pack_fill_s, word_r;
    logic [SW-1:0]           slot_r;
    logic                    cpl_r, cpl_last_r;

    // A held output word freezes the whole datapath, including the input side.
    assign stall_s      = out_valid && !out_ready;
    assign in_ready     = (state_r == RUN) && !stall_s;
    assign accept_s     = in_valid && in_ready;
    assign first_s      = (tap_cnt_r == 16'd0);
    assign tap_last_s   = (tap_cnt_r == (taps_r - 16'd1));
    assign layer_last_s = tap_last_s && (neu_cnt_r == (neurons_r - 16'd1));

    // Layer control FSM with tap/neuron counters and busy/done flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            taps_r    <= 16'd0;
            neurons_r <= 16'd0;
            tap_cnt_r <= 16'd0;
            neu_cnt_r <= 16'd0;
            relu_r    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (!stall_s) begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        taps_r    <= (cfg_taps == 16'd0) ? 16'd1 : cfg_taps;
                        neurons_r <= (cfg_neurons == 16'd0) ? 16'd1 : cfg_neurons;
                        relu_r    <= cfg_relu;
                        tap_cnt_r <= 16'd0;
                        neu_cnt_r <= 16'd0;
                        busy      <= 1'b1;
                        state_r   <= RUN;
                    end
                end
                RUN: begin
                    if (accept_s) begin
                        if (tap_last_s) begin
                            tap_cnt_r <= 16'd0;
                            neu_cnt_r <= neu_cnt_r + 16'd1;
                        end else begin
                            tap_cnt_r <= tap_cnt_r + 16'd1;
                        end
                        if (layer_last_s) begin
                            state_r <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (cpl_r && cpl_last_r) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Adder tree over the lane products and accumulator update value.
    always_comb begin
        sum_s = {ACCW{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            sum_s = sum_s + {{(ACCW-2*DW){prod_r[i][2*DW-1]}}, prod_r[i]};
        end
        if (first1_r) begin
            acc_nxt_s = sum_s;
        end else begin
            acc_nxt_s = acc_r + sum_s;
        end
    end

    // Post-processing: round-half-up rescale, saturate to DW bits, optional ReLU.
    always_comb begin
        rnd_s = fin_r + RND;
        shr_s = rnd_s >>> FRAC;
        if (shr_s > MAXV) begin
            sat_s = MAXV[DW-1:0];
        end else if (shr_s < MINV) begin
            sat_s = MINV[DW-1:0];
        end else begin
            sat_s = shr_s[DW-1:0];
        end
        if (relu_r && sat_s[DW-1]) begin
            res_s = {DW{1'b0}};
        end else begin
            res_s = sat_s;
        end
    end

    // Slot insertion into the partially filled word; slot 0 sits in the MSBs.
    always_comb begin
        pack_fill_s = pack_r;
        for (int i = 0; i < PACK; i++) begin
            if (slot_r == SW'(i)) begin
                pack_fill_s[(PACK-1-i)*DW +: DW] = res_s;
            end else begin
                pack_fill_s[(PACK-1-i)*DW +: DW] = pack_r[(PACK-1-i)*DW +: DW];
            end
        end
    end

    // Pipeline stages S1 (products), S2 (accumulate), packer and output word register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                prod_r[i] <= {(2*DW){1'b0}};
            end
            v1_r       <= 1'b0;
            first1_r   <= 1'b0;
            last1_r    <= 1'b0;
            llast1_r   <= 1'b0;
            acc_r      <= {ACCW{1'b0}};
            fin_r      <= {ACCW{1'b0}};
            v2_r       <= 1'b0;
            llast2_r   <= 1'b0;
            pack_r     <= {(PACK*DW){1'b0}};
            word_r     <= {(PACK*DW){1'b0}};
            slot_r     <= {SW{1'b0}};
            cpl_r      <= 1'b0;
            cpl_last_r <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= {(PACK*DW){1'b0}};
            out_last   <= 1'b0;
        end else if (!stall_s) begin
            v1_r <= accept_s;
            if (accept_s) begin
                for (int i = 0; i < LANES; i++) begin
                    prod_r[i] <= $signed(ifm[(LANES-1-i)*DW +: DW]) * $signed(wgt[(LANES-1-i)*DW +: DW]);
                end
                first1_r <= first_s;
                last1_r  <= tap_last_s;
                llast1_r <= layer_last_s;
            end

            // The final tap of a neuron bypasses the accumulator into the post-processor.
            v2_r     <= v1_r && last1_r;
            llast2_r <= v1_r && llast1_r;
            if (v1_r) begin
                if (last1_r) begin
                    fin_r <= acc_nxt_s;
                    acc_r <= {ACCW{1'b0}};
                end else begin
                    acc_r <= acc_nxt_s;
                end
            end

            cpl_r <= 1'b0;
            if (v2_r) begin
                if ((slot_r == SW'(PACK-1)) || llast2_r) begin
                    word_r     <= pack_fill_s;
                    pack_r     <= {(PACK*DW){1'b0}};
                    slot_r     <= {SW{1'b0}};
                    cpl_r      <= 1'b1;
                    cpl_last_r <= llast2_r;
                end else begin
                    pack_r <= pack_fill_s;
                    slot_r <= slot_r + {{(SW-1){1'b0}}, 1'b1};
                end
            end

            if (cpl_r) begin
                out_data  <= word_r;
                out_valid <= 1'b1;
                out_last  <= cpl_last_r;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_mac_pack.sv
// Self-checking bench for conv_mac_pack: directed layers plus random data/handshakes,
// each checked against a plain-arithmetic neuron model.
`timescale 1ns/1ps
module tb_conv_mac_pack;

    logic        clk = 1'b0;
    logic        rst_n, start, cfg_relu, in_valid, out_ready;
    logic [15:0] cfg_taps, cfg_neurons;
    logic [63:0] ifm, wgt, out_data;
    logic        in_ready, out_valid, out_last, busy, done;

    int total = 0;
    int bad   = 0;
    int lat;
    logic [63:0] b_ifm[$];
    logic [63:0] b_wgt[$];

    always #5 clk = ~clk;

    conv_mac_pack u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_taps(cfg_taps),
        .cfg_neurons(cfg_neurons), .cfg_relu(cfg_relu), .in_valid(in_valid),
        .in_ready(in_ready), .ifm(ifm), .wgt(wgt), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] small_word();
        logic [63:0] w;
        for (int l = 0; l < 4; l++) w[l*16 +: 16] = 16'($urandom_range(0, 1023)) - 16'd512;
        return w;
    endfunction

    task automatic fill(input int taps, input int neurons, input int kind);
        int n = ((taps == 0) ? 1 : taps) * ((neurons == 0) ? 1 : neurons);
        for (int i = 0; i < n; i++) begin
            if (kind == 0) begin
                b_ifm.push_back({$urandom, $urandom});
                b_wgt.push_back({$urandom, $urandom});
            end else begin
                b_ifm.push_back(small_word());
                b_wgt.push_back(small_word());
            end
        end
    endtask

    // smode: 0 = out_ready high, 1 = hold out_ready low 10 cycles once a word pends, 2 = random out_ready
    task automatic run_layer(input string nm, input int taps, input int neurons, input bit relu,
                             input int smode, input int vprob, input bit mid_start, output int lat_o);
        int et, en, nb, bi, wi, cyc, hold, acc_last, ov1;
        bit fin, stable, saw_rdy;
        longint acc, r;
        shortint x, y;
        logic [63:0] a, b, w, snap;
        logic [63:0] ew[$];
        bit el[$];
        logic [15:0] res[$];

        et = (taps == 0) ? 1 : taps;
        en = (neurons == 0) ? 1 : neurons;
        nb = et * en;
        for (int n = 0; n < en; n++) begin
            acc = 0;
            for (int t = 0; t < et; t++) begin
                a = b_ifm[n*et + t];
                b = b_wgt[n*et + t];
                for (int l = 0; l < 4; l++) begin
                    x = shortint'(a[(3-l)*16 +: 16]);
                    y = shortint'(b[(3-l)*16 +: 16]);
                    acc += longint'(x) * longint'(y);
                end
            end
            r = (acc + 128) >>> 8;
            if (r > 32767) r = 32767;
            else if (r < -32768) r = -32768;
            if (relu && r < 0) r = 0;
            res.push_back(16'(r));
        end
        for (int k = 0; k < res.size(); k += 4) begin
            w = 64'd0;
            for (int s = 0; s < 4; s++) if (k + s < res.size()) w[(3-s)*16 +: 16] = res[k+s];
            ew.push_back(w);
            el.push_back(k + 4 >= res.size());
        end

        @(negedge clk);
        cfg_taps = 16'(taps); cfg_neurons = 16'(neurons); cfg_relu = relu;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_busy_on"}, busy, 64'd1);

        bi = 0; wi = 0; cyc = 0; hold = 0; acc_last = -1; ov1 = -1;
        fin = 0; stable = 1; saw_rdy = 0; snap = 64'd0;
        while (!fin && cyc < 5000) begin
            @(negedge clk);
            start = (mid_start && cyc == 3);
            if (mid_start && cyc == 3) cfg_taps = 16'd7;
            in_valid = (bi < nb) && ($urandom_range(0, 99) < vprob);
            ifm = (bi < nb) ? b_ifm[bi] : {$urandom, $urandom};
            wgt = (bi < nb) ? b_wgt[bi] : {$urandom, $urandom};
            if (smode == 1 && out_valid && hold < 10) begin
                out_ready = 1'b0;
                if (hold == 0) snap = out_data;
                else if (out_data !== snap) stable = 0;
                hold++;
            end else if (smode == 2) begin
                out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                out_ready = 1'b1;
            end
            #1;
            if (!out_ready && in_ready) saw_rdy = 1;
            if (in_valid && in_ready) begin
                if (bi == nb - 1) acc_last = cyc;
                bi++;
            end
            if (out_valid && ov1 < 0) ov1 = cyc;
            if (out_valid && out_ready) begin
                if (wi < ew.size()) begin
                    chk($sformatf("%s_word%0d", nm, wi), out_data, ew[wi]);
                    chk($sformatf("%s_last%0d", nm, wi), out_last, el[wi]);
                end else begin
                    chk($sformatf("%s_extra_word%0d", nm, wi), 64'd1, 64'd0);
                end
                wi++;
                if (out_last) fin = 1;
            end
            cyc++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk({nm, "_finished"}, fin, 64'd1);
        chk({nm, "_word_count"}, wi, ew.size());
        if (smode == 1) begin
            chk({nm, "_bp_hold"}, hold, 64'd10);
            chk({nm, "_bp_in_ready"}, saw_rdy, 64'd0);
            chk({nm, "_bp_stable"}, stable, 64'd1);
        end
        @(posedge clk); #1;
        chk({nm, "_done_pulse"}, done, 64'd1);
        chk({nm, "_busy_off"}, busy, 64'd0);
        chk({nm, "_ov_off"}, out_valid, 64'd0);
        @(posedge clk); #1;
        chk({nm, "_done_clear"}, done, 64'd0);
        lat_o = ov1 - acc_last;
        b_ifm.delete();
        b_wgt.delete();
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0; start = 1'b0; cfg_relu = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cfg_taps = 16'd1; cfg_neurons = 16'd1; ifm = 64'd0; wgt = 64'd0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 64'd0);
        chk("rst_out_valid", out_valid, 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_last", out_last, 64'd0);
        chk("rst_busy", busy, 64'd0);
        chk("rst_done", done, 64'd0);
        rst_n = 1'b1;

        // Basic 4-neuron single-tap layer with latency check.
        for (int i = 0; i < 4; i++) begin
            b_ifm.push_back({4{16'h0100}});
            b_wgt.push_back({4{16'h0100}});
        end
        run_layer("basic", 1, 4, 1'b0, 0, 100, 1'b0, lat);
        chk("basic_latency", lat, 64'd4);

        // Three taps, five neurons, lane 0 only: partial final word.
        for (int i = 0; i < 15; i++) begin
            b_ifm.push_back({16'h0200, 48'd0});
            b_wgt.push_back({16'h0080, 48'd0});
        end
        run_layer("taps3", 3, 5, 1'b0, 0, 100, 1'b0, lat);

        // Saturation high, low, and low with ReLU.
        for (int i = 0; i < 16; i++) begin b_ifm.push_back({4{16'h7FFF}}); b_wgt.push_back({4{16'h7FFF}}); end
        run_layer("sat_hi", 4, 4, 1'b0, 0, 100, 1'b0, lat);
        for (int i = 0; i < 16; i++) begin b_ifm.push_back({4{16'h8000}}); b_wgt.push_back({4{16'h7FFF}}); end
        run_layer("sat_lo", 4, 4, 1'b0, 0, 100, 1'b0, lat);
        for (int i = 0; i < 16; i++) begin b_ifm.push_back({4{16'h8000}}); b_wgt.push_back({4{16'h7FFF}}); end
        run_layer("relu", 4, 4, 1'b1, 0, 100, 1'b0, lat);

        // Rounding: 0x180 -> 2, 0x17F -> 1, -0x180 -> -1, 0x80 -> 1.
        b_ifm.push_back({16'h0180, 48'd0}); b_wgt.push_back({16'h0001, 48'd0});
        b_ifm.push_back({16'h017F, 48'd0}); b_wgt.push_back({16'h0001, 48'd0});
        b_ifm.push_back({16'hFE80, 48'd0}); b_wgt.push_back({16'h0001, 48'd0});
        b_ifm.push_back({16'h0080, 48'd0}); b_wgt.push_back({16'h0001, 48'd0});
        run_layer("round", 1, 4, 1'b0, 0, 100, 1'b0, lat);

        // Backpressure with held out_ready, then random traffic and an ignored mid-layer start.
        fill(2, 9, 1);
        run_layer("bp", 2, 9, 1'b0, 1, 100, 1'b0, lat);
        fill(3, 6, 1);
        run_layer("rand_small", 3, 6, 1'b1, 2, 60, 1'b1, lat);
        fill(2, 7, 0);
        run_layer("rand_full", 2, 7, 1'b0, 2, 70, 1'b0, lat);

        // Reset in the middle of a neuron: outputs clear at once and nothing is emitted.
        fill(4, 4, 1);
        @(negedge clk);
        cfg_taps = 16'd4; cfg_neurons = 16'd4; cfg_relu = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; ifm = b_ifm[i]; wgt = b_wgt[i];
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 64'd0);
        chk("midrst_out_valid", out_valid, 64'd0);
        chk("midrst_busy", busy, 64'd0);
        chk("midrst_out_data", out_data, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1;
        end
        in_valid = 1'b0;
        chk("midrst_no_output", seen, 64'd0);
        b_ifm.delete();
        b_wgt.delete();

        // cfg_taps = 0 behaves as one tap.
        fill(0, 3, 1);
        run_layer("taps0", 0, 3, 1'b0, 0, 100, 1'b0, lat);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
